// File: rtl/coin_credit_fsm.sv
// -----------------------------------------------------------------------------
// coin_credit_fsm
//
// Coin-operated vending controller. It accumulates credit from 1/2/5-unit
// coins and sells one of four products. A sale leaves the change on `change`.
// A cancel returns the whole credit through `change`. The vend or refund strobe
// is held for VEND_HOLD cycles. Requests that cannot be honoured are ignored,
// and `reject` pulses for one cycle.
//
// Parameters
//   VEND_HOLD      cycles that vend/refund stay high (1..15)
//   PRICE0..3      product price in credit units for sel = 0..3
//
// Ports
//   clk     in   1  clock, rising edge active
//   rst     in   1  asynchronous, active-high reset
//   coin    in   3  level inputs; rising edge = coin inserted
//                   (bit0 = 1 unit, bit1 = 2 units, bit2 = 5 units)
//   sel     in   2  product select
//   buy     in   1  level input; rising edge = purchase request
//   cancel  in   1  level input; rising edge = refund request
//   credit  out  5  accumulated credit (0..31)
//   change  out  5  change / refund amount, valid while vend or refund
//   product out  2  product being dispensed, valid while vend
//   vend    out  1  dispense strobe
//   refund  out  1  refund strobe
//   reject  out  1  one-cycle pulse for an ignored coin or request
//   busy    out  1  high while dispensing or refunding
//
// Every output is registered. An event detected at rising edge k becomes
// visible just after edge k. The inputs are assumed to be synchronous to clk.
// -----------------------------------------------------------------------------
module coin_credit_fsm #(
    parameter int VEND_HOLD = 4,
    parameter int PRICE0    = 1,
    parameter int PRICE1    = 3,
    parameter int PRICE2    = 5,
    parameter int PRICE3    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin,
    input  logic [1:0] sel,
    input  logic       buy,
    input  logic       cancel,
    output logic [4:0] credit,
    output logic [4:0] change,
    output logic [1:0] product,
    output logic       vend,
    output logic       refund,
    output logic       reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,      // credit == 0
        S_CREDIT,    // credit  > 0
        S_DISPENSE,  // vend strobe active
        S_REFUND     // refund strobe active
    } state_t;

    localparam logic [3:0] HOLD_LOAD  = 4'(VEND_HOLD);
    localparam logic [5:0] CREDIT_MAX = 6'd31;

    state_t     state, state_nxt;
    logic [3:0] hold, hold_nxt;

    logic [4:0] credit_nxt;
    logic [4:0] change_nxt;
    logic [1:0] product_nxt;
    logic       vend_nxt;
    logic       refund_nxt;
    logic       reject_nxt;
    logic       busy_nxt;

    // Previous input levels used for rising-edge detection.
    logic [2:0] coin_q;
    logic       buy_q;
    logic       cancel_q;

    logic [2:0] coin_ev;
    logic       coin_any;
    logic       buy_ev;
    logic       cancel_ev;

    logic [5:0] coin_sum;
    logic [5:0] credit_ext;
    logic [5:0] credit_sum;
    logic [5:0] price;

    // -------------------------------------------------------------------------
    // Event detection and arithmetic
    // -------------------------------------------------------------------------
    assign coin_ev   = coin & ~coin_q;
    assign coin_any  = |coin_ev;
    assign buy_ev    = buy & ~buy_q;
    assign cancel_ev = cancel & ~cancel_q;

    // The sum is computed 6 bits wide, so 31 + 8 cannot wrap. An overflowing
    // insertion is therefore always seen and rejected.
    assign coin_sum   = (coin_ev[0] ? 6'd1 : 6'd0)
                      + (coin_ev[1] ? 6'd2 : 6'd0)
                      + (coin_ev[2] ? 6'd5 : 6'd0);
    assign credit_ext = {1'b0, credit};
    assign credit_sum = credit_ext + coin_sum;

    always_comb begin
        case (sel)
            2'd0:    price = 6'(PRICE0);
            2'd1:    price = 6'(PRICE1);
            2'd2:    price = 6'(PRICE2);
            default: price = 6'(PRICE3);
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here, before any branch. Then no
        // path through the case can leave a value unassigned and infer a latch.
        state_nxt   = state;
        hold_nxt    = hold;
        credit_nxt  = credit;
        change_nxt  = change;
        product_nxt = product;
        vend_nxt    = vend;
        refund_nxt  = refund;
        reject_nxt  = 1'b0;

        case (state)
            S_IDLE, S_CREDIT: begin
                // Priority is cancel > buy > coin. A lower-priority event in
                // the same cycle is dropped and reported with one reject pulse.
                // A cancel with no credit to return counts as no event.
                if (cancel_ev && state == S_CREDIT) begin
                    change_nxt = credit;
                    credit_nxt = 5'd0;
                    hold_nxt   = HOLD_LOAD;
                    refund_nxt = 1'b1;
                    state_nxt  = S_REFUND;
                    reject_nxt = buy_ev | coin_any;
                end else if (buy_ev) begin
                    // The buy is judged against the credit held before this
                    // cycle. Coins arriving in the same cycle never count.
                    if (credit_ext >= price) begin
                        change_nxt  = 5'(credit_ext - price);
                        product_nxt = sel;
                        credit_nxt  = 5'd0;
                        hold_nxt    = HOLD_LOAD;
                        vend_nxt    = 1'b1;
                        state_nxt   = S_DISPENSE;
                        reject_nxt  = coin_any;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (coin_any) begin
                    if (credit_sum <= CREDIT_MAX) begin
                        credit_nxt = credit_sum[4:0];
                        state_nxt  = S_CREDIT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end

            S_DISPENSE, S_REFUND: begin
                reject_nxt = coin_any | buy_ev | cancel_ev;
                // The strobe is already high for the cycle that loaded the
                // counter. Leaving when the count would reach zero therefore
                // gives exactly VEND_HOLD strobe cycles.
                if (hold <= 4'd1) begin
                    hold_nxt   = 4'd0;
                    vend_nxt   = 1'b0;
                    refund_nxt = 1'b0;
                    change_nxt = 5'd0;
                    state_nxt  = S_IDLE;
                end else begin
                    hold_nxt = hold - 4'd1;
                end
            end

            default: begin
                hold_nxt   = 4'd0;
                credit_nxt = 5'd0;
                change_nxt = 5'd0;
                vend_nxt   = 1'b0;
                refund_nxt = 1'b0;
                state_nxt  = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_DISPENSE) || (state_nxt == S_REFUND);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hold     <= 4'd0;
            credit   <= 5'd0;
            change   <= 5'd0;
            product  <= 2'd0;
            vend     <= 1'b0;
            refund   <= 1'b0;
            reject   <= 1'b0;
            busy     <= 1'b0;
            coin_q   <= 3'd0;
            buy_q    <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples values
            // from before the edge. Edge detection relies on this.
            state    <= state_nxt;
            hold     <= hold_nxt;
            credit   <= credit_nxt;
            change   <= change_nxt;
            product  <= product_nxt;
            vend     <= vend_nxt;
            refund   <= refund_nxt;
            reject   <= reject_nxt;
            busy     <= busy_nxt;
            coin_q   <= coin;
            buy_q    <= buy;
            cancel_q <= cancel;
        end
    end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// -----------------------------------------------------------------------------
// tb_coin_credit_fsm
//
// Self-checking bench for coin_credit_fsm. Two instances (VEND_HOLD = 4 and
// VEND_HOLD = 1) receive identical stimulus. Each one is compared, every cycle,
// with a behavioural model built from credit arithmetic and a remaining-cycles
// count. Directed scenarios come first, followed by randomized traffic with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_coin_credit_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] coin;
    logic [1:0] sel;
    logic       buy;
    logic       cancel;

    logic [1:0][4:0] credit_o;
    logic [1:0][4:0] change_o;
    logic [1:0][1:0] product_o;
    logic [1:0]      vend_o;
    logic [1:0]      refund_o;
    logic [1:0]      reject_o;
    logic [1:0]      busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coin_credit_fsm #(.VEND_HOLD(4)) dut0 (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
        .credit(credit_o[0]), .change(change_o[0]), .product(product_o[0]),
        .vend(vend_o[0]), .refund(refund_o[0]), .reject(reject_o[0]), .busy(busy_o[0])
    );

    coin_credit_fsm #(.VEND_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .buy(buy), .cancel(cancel),
        .credit(credit_o[1]), .change(change_o[1]), .product(product_o[1]),
        .vend(vend_o[1]), .refund(refund_o[1]), .reject(reject_o[1]), .busy(busy_o[1])
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        int       credit;
        int       change;
        int       product;
        int       remaining;   // strobe cycles still to come, including this one
        bit       vend;
        bit       refund;
        bit       reject;
        bit [2:0] pc;
        bit       pb;
        bit       px;
        int       hold;
    } model_t;

    model_t m [2];
    int price_tab [4] = '{1, 3, 5, 10};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
        m[0].hold = 4;
        m[1].hold = 1;
    endtask

    task automatic step_model(input int i);
        model_t   t;
        bit [2:0] ce;
        bit       be, xe;
        int       s, p;
        t  = m[i];
        ce = coin & ~t.pc;
        be = buy && !t.pb;
        xe = cancel && !t.px;
        s  = (ce[0] ? 1 : 0) + (ce[1] ? 2 : 0) + (ce[2] ? 5 : 0);
        t.reject = 0;
        if (t.remaining > 0) begin
            t.reject = (ce != 0) || be || xe;
            t.remaining--;
            if (t.remaining == 0) begin
                t.vend = 0; t.refund = 0; t.change = 0;
            end
        end else if (xe && t.credit > 0) begin
            t.change = t.credit; t.credit = 0; t.refund = 1;
            t.remaining = t.hold;
            t.reject = be || (ce != 0);
        end else if (be) begin
            p = price_tab[sel];
            if (t.credit >= p) begin
                t.change = t.credit - p; t.product = sel; t.credit = 0;
                t.vend = 1; t.remaining = t.hold;
                t.reject = (ce != 0);
            end else begin
                t.reject = 1;
            end
        end else if (ce != 0) begin
            if (t.credit + s <= 31) t.credit += s;
            else t.reject = 1;
        end
        t.pc = coin; t.pb = buy; t.px = cancel;
        m[i] = t;
    endtask

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("credit[%0d]", i), 32'(credit_o[i]), 32'(m[i].credit));
            check($sformatf("change[%0d]", i), 32'(change_o[i]), 32'(m[i].change));
            check($sformatf("vend[%0d]", i),   32'(vend_o[i]),   32'(m[i].vend));
            check($sformatf("refund[%0d]", i), 32'(refund_o[i]), 32'(m[i].refund));
            check($sformatf("reject[%0d]", i), 32'(reject_o[i]), 32'(m[i].reject));
            check($sformatf("busy[%0d]", i),   32'(busy_o[i]),   32'(m[i].remaining > 0));
            if (m[i].vend)
                check($sformatf("product[%0d]", i), 32'(product_o[i]), 32'(m[i].product));
            check($sformatf("one_strobe[%0d]", i), 32'(vend_o[i] & refund_o[i]), 32'd0);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic cycle(input logic [2:0] c, input logic [1:0] s,
                         input logic b, input logic x);
        coin = c; sel = s; buy = b; cancel = x;
        @(posedge clk);
        step_model(0);
        step_model(1);
        #1;
        compare_all();
    endtask

    // Assert reset between clock edges. Check that the outputs clear without a
    // clock edge, then release reset on the next falling edge.
    task automatic apply_reset(input logic [2:0] c);
        coin = c; sel = 2'd0; buy = 1'b0; cancel = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        m[0].pc = 3'd0; m[1].pc = 3'd0;
    endtask

    int nv, nr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        coin = 3'd0; sel = 2'd0; buy = 1'b0; cancel = 1'b0; rst = 1'b1;
        #2;
        apply_reset(3'd0);

        // Coins 5, 5, 1, then buy product 3 (price 10).
        cycle(3'b100, 2'd0, 0, 0); check("r31_credit5",  32'(credit_o[0]), 32'd5);
        cycle(3'b000, 2'd0, 0, 0);
        cycle(3'b100, 2'd0, 0, 0); check("r31_credit10", 32'(credit_o[0]), 32'd10);
        cycle(3'b000, 2'd0, 0, 0);
        cycle(3'b001, 2'd0, 0, 0); check("r31_credit11", 32'(credit_o[0]), 32'd11);
        cycle(3'b000, 2'd3, 0, 0);
        cycle(3'b000, 2'd3, 1, 0);
        check("r31_vend",    32'(vend_o[0]),    32'd1);
        check("r31_product", 32'(product_o[0]), 32'd3);
        check("r31_change",  32'(change_o[0]),  32'd1);
        check("r31_credit0", 32'(credit_o[0]),  32'd0);
        nv = 1;
        repeat (6) begin cycle(3'b000, 2'd3, 0, 0); nv += int'(vend_o[0]); end
        check("r31_vend_len", 32'(nv), 32'd4);
        check("r31_idle",     32'(busy_o[0]), 32'd0);

        // Buy with too little credit.
        apply_reset(3'd0);
        cycle(3'b011, 2'd2, 0, 0); check("r32_credit3", 32'(credit_o[0]), 32'd3);
        cycle(3'b000, 2'd2, 0, 0);
        cycle(3'b000, 2'd2, 1, 0);
        check("r32_reject", 32'(reject_o[0]), 32'd1);
        check("r32_credit", 32'(credit_o[0]), 32'd3);
        check("r32_vend",   32'(vend_o[0]),   32'd0);
        cycle(3'b000, 2'd2, 0, 0);
        check("r32_reject_once", 32'(reject_o[0]), 32'd0);

        // Saturation at 31.
        apply_reset(3'd0);
        repeat (6) begin cycle(3'b100, 2'd0, 0, 0); cycle(3'b000, 2'd0, 0, 0); end
        check("r33_credit30", 32'(credit_o[0]), 32'd30);
        cycle(3'b010, 2'd0, 0, 0);
        check("r33_reject",   32'(reject_o[0]), 32'd1);
        check("r33_credit_held", 32'(credit_o[0]), 32'd30);
        cycle(3'b000, 2'd0, 0, 0);
        cycle(3'b001, 2'd0, 0, 0);
        check("r33_credit31", 32'(credit_o[0]), 32'd31);

        // Cancel and an affordable buy in the same cycle: cancel wins.
        apply_reset(3'd0);
        cycle(3'b110, 2'd2, 0, 0); check("r34_credit7", 32'(credit_o[0]), 32'd7);
        cycle(3'b000, 2'd2, 0, 0);
        cycle(3'b000, 2'd2, 1, 1);
        check("r34_refund", 32'(refund_o[0]), 32'd1);
        check("r34_change", 32'(change_o[0]), 32'd7);
        check("r34_reject", 32'(reject_o[0]), 32'd1);
        nr = 1; nv = int'(vend_o[0]);
        repeat (6) begin
            cycle(3'b000, 2'd2, 0, 0);
            nr += int'(refund_o[0]); nv += int'(vend_o[0]);
        end
        check("r34_refund_len", 32'(nr), 32'd4);
        check("r34_no_vend",    32'(nv), 32'd0);

        // Coin during dispense, then reset mid-dispense.
        apply_reset(3'd0);
        cycle(3'b100, 2'd2, 0, 0);
        cycle(3'b000, 2'd2, 0, 0);
        cycle(3'b000, 2'd2, 1, 0); check("r35_vend", 32'(vend_o[0]), 32'd1);
        cycle(3'b001, 2'd2, 0, 0);
        check("r35_reject", 32'(reject_o[0]), 32'd1);
        check("r35_credit", 32'(credit_o[0]), 32'd0);
        apply_reset(3'd0);
        check("r35_vend_rst", 32'(vend_o[0]), 32'd0);
        nv = 0;
        repeat (5) begin cycle(3'b000, 2'd2, 0, 0); nv += int'(vend_o[0]); end
        check("r35_no_resume", 32'(nv), 32'd0);

        // VEND_HOLD = 1 instance: a single vend cycle.
        apply_reset(3'd0);
        cycle(3'b001, 2'd0, 0, 0);
        cycle(3'b000, 2'd0, 0, 0);
        cycle(3'b000, 2'd0, 1, 0);
        check("r36_vend",   32'(vend_o[1]),   32'd1);
        check("r36_change", 32'(change_o[1]), 32'd0);
        cycle(3'b000, 2'd0, 0, 0);
        check("r36_vend_off", 32'(vend_o[1]), 32'd0);

        // An input held high through reset counts as an edge on the first clock.
        apply_reset(3'b001);
        cycle(3'b001, 2'd0, 0, 0);
        check("r30_edge_after_rst", 32'(credit_o[0]), 32'd1);

        // Randomized traffic.
        apply_reset(3'd0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0)
                apply_reset(3'($urandom));
            else
                cycle(3'($urandom) & 3'($urandom), 2'($urandom),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
